proc_sequencer: RTL and testbench
=================================

// Module: proc_sequencer
// PURPOSE
//  Top-level run controller for the single-cycle MIPS datapath; replaces the testbench-driven init loop.
//  Sequences: load program into instr_mem -> release PC and run -> halt/timeout -> dump RegisterFile
//  and data_mem contents through address muxes on a dump stream. Sits beside control_unit in mips_proc.
// PARAMETERS
//  HALT_INSTR  32'hFFFFFFFF  instruction word that ends RUN (never executed)
//  MAX_CYCLES  16'd1000      RUN cycle budget; reaching it ends RUN with timeout
//  NUM_REGS    32            registers dumped, indices 0..NUM_REGS-1
//  DMEM_WORDS  64            data_mem words dumped, byte addresses 0,4,..,4*(DMEM_WORDS-1)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  resetN       in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse; accepted only in IDLE or DONE
//  progLen      in   8   number of program words; sampled on accepted start
//  progIdx      out  8   index of program word requested from external program source
//  progWord     in   32  program word for progIdx, combinational, same cycle
//  initializing out  1   1 in LOAD; top muxes instrAddr to instrAddrLoad
//  instrAddrLoad out 32  progIdx*4 during LOAD, else 0
//  instrIn      out  32  = progWord during LOAD, else 0
//  instrWrite   out  1   instr_mem write strobe, 1 in LOAD only
//  instrRead    out  1   1 in RUN only
//  pcReset      out  1   1 in IDLE/LOAD/DONE and during reset; 0 in RUN/dump
//  pcWrite      out  1   1 in RUN unless halt detected this cycle
//  execEn       out  1   = pcWrite; top ANDs regWrite and memWrite with it
//  curInstr     in   32  instruction currently fetched by instr_mem
//  regDumpSel   out  1   1 in DUMP_REG: top muxes readReg1 to regDumpAddr
//  regDumpAddr  out  5   register index being dumped
//  regDumpData  in   32  regData1 (combinational read)
//  memDumpSel   out  1   1 in DUMP_MEM: top muxes data_mem addr/read
//  memDumpAddr  out  32  data_mem byte address; memDumpRead out 1 = memDumpSel
//  memDumpData  in   32  memData, valid 1 cycle after address
//  dumpValid    out  1   dump beat valid; dumpKind out 1 (0=reg,1=mem); dumpIndex out 16
//  dumpData     out  32  dumped value
//  cycleNo      out  16  RUN cycles elapsed; busy, done, timeout out 1 each
// BEHAVIOUR
//  Reset (async, any state): state IDLE, all counters 0, all outputs 0 except pcReset=1.
//  States IDLE->LOAD->RUN->DUMP_REG->DUMP_MEM->DONE; busy=1 in LOAD..DUMP_MEM.
//  IDLE: start -> LOAD (progLen!=0) or DUMP_REG (progLen==0); clears cycleNo, timeout, done.
//  LOAD: one word per cycle, progIdx 0..progLen-1, instrWrite=1; after last write -> RUN.
//  RUN: cycleNo += 1 per cycle (registered). If curInstr==HALT_INSTR: pcWrite=execEn=0 that cycle,
//   -> DUMP_REG. Else if cycleNo==MAX_CYCLES-1: timeout<=1, that cycle still executes, -> DUMP_REG.
//   Halt and budget in same cycle: halt wins, timeout stays 0. cycleNo saturates, never wraps.
//  DUMP_REG: NUM_REGS cycles, regDumpAddr=k; dumpValid=1, dumpKind=0, dumpIndex=k, dumpData=regDumpData
//   same cycle (0 latency). After k=NUM_REGS-1 -> DUMP_MEM.
//  DUMP_MEM: addresses issued for DMEM_WORDS cycles, plus one drain cycle; beat k (dumpKind=1,
//   dumpIndex=k) appears the cycle after address 4k. Total DMEM_WORDS+1 cycles, then DONE.
//  DONE: done=1, pcReset=1, outputs otherwise idle; start -> restart as from IDLE. start ignored elsewhere.
//  dumpValid never asserted outside dump states; exactly NUM_REGS+DMEM_WORDS beats per run.
// STRUCTURE
//  Shared package mips_pkg: state encoding (IDLE,LOAD,RUN,DUMP_REG,DUMP_MEM,DONE), HALT_INSTR default.
//  Single module; one index counter reused by LOAD/DUMP_REG/DUMP_MEM, separate cycleNo counter.
//  No sub-module; registered state + counters, Moore decode for mux selects and strobes.
// TESTING
//  progLen=2 {20100002,22100003,FFFFFFFF}... start -> 2 instrWrite beats at addr 0,4; beat order correct.
//  Program addi $s0,2; addi $s0,3; HALT -> cycleNo=3, timeout=0, reg beat 16 dumpData=5, PC not advanced past halt.
//  Program of NOPs, no halt, MAX_CYCLES=10 -> timeout=1, cycleNo=10, exactly 32+64 dump beats.
//  sw of 0xDEADBEEF to addr 8 then HALT -> mem beat index 2 = DEADBEEF, arriving 1 cycle after addr 8.
//  resetN low mid-DUMP_REG -> immediate IDLE, dumpValid=0, pcReset=1; fresh start reruns cleanly.
//  progLen=0 -> no instrWrite, no RUN cycles, dump still emits 96 beats, done=1; start in RUN ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS run controller: sequencer state encoding and
// default halt/budget constants.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DONE
    } seq_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [15:0] MAX_CYCLES_DEFAULT = 16'd1000;

endpackage

// File: rtl/proc_sequencer.sv
// Run controller for the single-cycle MIPS datapath: loads the program, runs until
// halt or cycle budget, then streams out the register file and data memory.
module proc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter logic [15:0] MAX_CYCLES = MAX_CYCLES_DEFAULT,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [7:0]  progLen,
    output logic [7:0]  progIdx,
    input  logic [31:0] progWord,
    output logic        initializing,
    output logic [31:0] instrAddrLoad,
    output logic [31:0] instrIn,
    output logic        instrWrite,
    output logic        instrRead,
    output logic        pcReset,
    output logic        pcWrite,
    output logic        execEn,
    input  logic [31:0] curInstr,
    output logic        regDumpSel,
    output logic [4:0]  regDumpAddr,
    input  logic [31:0] regDumpData,
    output logic        memDumpSel,
    output logic [31:0] memDumpAddr,
    output logic        memDumpRead,
    input  logic [31:0] memDumpData,
    output logic        dumpValid,
    output logic        dumpKind,
    output logic [15:0] dumpIndex,
    output logic [31:0] dumpData,
    output logic [15:0] cycleNo,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam logic [15:0] REG_LAST  = 16'(NUM_REGS - 1);
    localparam logic [15:0] MEM_WORDS = 16'(DMEM_WORDS);

    seq_state_e  state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] cycle_q, cycle_d;
    logic        timeout_q, timeout_d;
    logic        halt;

    assign halt = (state_q == S_RUN) && (curInstr == HALT_INSTR);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cycle_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cycle_q   <= cycle_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cycle_d   = cycle_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d     = progLen;
                    idx_d     = '0;
                    cycle_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = (progLen != 8'd0) ? S_LOAD : S_DUMP_REG;
                end
            end
            S_LOAD: begin
                if (idx_q == 16'(len_q - 8'd1)) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            S_RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + 16'd1;
                // Halt takes priority over the budget check, so timeout stays clear.
                if (halt) begin
                    state_d = S_DUMP_REG;
                end else if (cycle_q == MAX_CYCLES - 16'd1) begin
                    timeout_d = 1'b1;
                    state_d   = S_DUMP_REG;
                end
            end
            S_DUMP_REG: begin
                if (idx_q == REG_LAST) begin
                    idx_d   = '0;
                    state_d = S_DUMP_MEM;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            S_DUMP_MEM: begin
                // Index runs one past the last word to drain the read latency.
                if (idx_q == MEM_WORDS) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        progIdx       = '0;
        initializing  = 1'b0;
        instrAddrLoad = '0;
        instrIn       = '0;
        instrWrite    = 1'b0;
        instrRead     = 1'b0;
        pcReset       = 1'b0;
        pcWrite       = 1'b0;
        regDumpSel    = 1'b0;
        regDumpAddr   = '0;
        memDumpSel    = 1'b0;
        memDumpAddr   = '0;
        dumpValid     = 1'b0;
        dumpKind      = 1'b0;
        dumpIndex     = '0;
        dumpData      = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: pcReset = 1'b1;
            S_LOAD: begin
                pcReset       = 1'b1;
                busy          = 1'b1;
                initializing  = 1'b1;
                instrWrite    = 1'b1;
                progIdx       = idx_q[7:0];
                instrAddrLoad = {22'd0, idx_q[7:0], 2'b00};
                instrIn       = progWord;
            end
            S_RUN: begin
                busy      = 1'b1;
                instrRead = 1'b1;
                pcWrite   = !halt;
            end
            S_DUMP_REG: begin
                busy        = 1'b1;
                regDumpSel  = 1'b1;
                regDumpAddr = idx_q[4:0];
                dumpValid   = 1'b1;
                dumpIndex   = idx_q;
                dumpData    = regDumpData;
            end
            S_DUMP_MEM: begin
                busy       = 1'b1;
                memDumpSel = 1'b1;
                if (idx_q < MEM_WORDS) memDumpAddr = {14'd0, idx_q, 2'b00};
                dumpValid  = (idx_q != 16'd0);
                dumpKind   = 1'b1;
                dumpIndex  = idx_q - 16'd1;
                dumpData   = memDumpData;
            end
            S_DONE: begin
                pcReset = 1'b1;
                done    = 1'b1;
            end
            default: pcReset = 1'b1;
        endcase
    end

    assign execEn      = pcWrite;
    assign memDumpRead = memDumpSel;
    assign cycleNo     = cycle_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a behavioural datapath stand-in plus an instruction-level
// reference model of each run, driven by fixed vectors and random programs.
module tb_proc_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int unsigned MAXC = 10;
    localparam int unsigned NREG = 32;
    localparam int unsigned NMEM = 64;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  progLen = '0;
    logic [7:0]  progIdx;
    logic [31:0] progWord;
    logic        initializing, instrWrite, instrRead, pcReset, pcWrite, execEn;
    logic [31:0] instrAddrLoad, instrIn, curInstr;
    logic        regDumpSel, memDumpSel, memDumpRead;
    logic [4:0]  regDumpAddr;
    logic [31:0] regDumpData, memDumpAddr, memDumpData, dumpData;
    logic        dumpValid, dumpKind, busy, done, timeout;
    logic [15:0] dumpIndex, cycleNo;

    proc_sequencer #(.HALT_INSTR(HALT), .MAX_CYCLES(16'(MAXC)), .NUM_REGS(NREG), .DMEM_WORDS(NMEM)) dut (
        .clk(clk), .resetN(resetN), .start(start), .progLen(progLen), .progIdx(progIdx),
        .progWord(progWord), .initializing(initializing), .instrAddrLoad(instrAddrLoad),
        .instrIn(instrIn), .instrWrite(instrWrite), .instrRead(instrRead), .pcReset(pcReset),
        .pcWrite(pcWrite), .execEn(execEn), .curInstr(curInstr), .regDumpSel(regDumpSel),
        .regDumpAddr(regDumpAddr), .regDumpData(regDumpData), .memDumpSel(memDumpSel),
        .memDumpAddr(memDumpAddr), .memDumpRead(memDumpRead), .memDumpData(memDumpData),
        .dumpValid(dumpValid), .dumpKind(dumpKind), .dumpIndex(dumpIndex), .dumpData(dumpData),
        .cycleNo(cycleNo), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] data;
    } eff_t;

    // addi / lui / ori / sw; anything else behaves as a NOP
    function automatic eff_t decode(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
        eff_t e;
        logic [31:0] se;
        e  = '0;
        se = {{16{ins[15]}}, ins[15:0]};
        case (ins[31:26])
            6'h08: begin e.wr = 1'b1; e.rd = ins[20:16]; e.val = rsv + se; end
            6'h0F: begin e.wr = 1'b1; e.rd = ins[20:16]; e.val = {ins[15:0], 16'h0000}; end
            6'h0D: begin e.wr = 1'b1; e.rd = ins[20:16]; e.val = rsv | {16'h0000, ins[15:0]}; end
            6'h2B: begin e.mw = 1'b1; e.addr = rsv + se; e.data = rtv; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // ---- datapath stand-in: instr_mem, PC, register file, data_mem ----
    logic [31:0] imem [256];
    logic [31:0] prog_buf [256];
    logic [31:0] e_regs [32];
    logic [31:0] e_dmem [64];
    logic [31:0] env_pc = '0;
    logic [31:0] mem_rd_q = '0;
    logic        env_clr = 1'b0;
    eff_t        env_eff;

    assign curInstr    = imem[env_pc[9:2]];
    assign progWord    = prog_buf[progIdx];
    assign regDumpData = e_regs[regDumpAddr];
    assign memDumpData = mem_rd_q;
    assign env_eff     = decode(curInstr, e_regs[curInstr[25:21]], e_regs[curInstr[20:16]]);

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 256; i++) imem[i] <= '0;
            for (int i = 0; i < 32; i++) e_regs[i] <= '0;
            for (int i = 0; i < 64; i++) e_dmem[i] <= '0;
            env_pc   <= '0;
            mem_rd_q <= '0;
        end else begin
            if (instrWrite) imem[instrAddrLoad[9:2]] <= instrIn;
            if (pcReset) env_pc <= '0;
            else if (pcWrite) env_pc <= env_pc + 32'd4;
            if (execEn) begin
                if (env_eff.wr && env_eff.rd != 5'd0) e_regs[env_eff.rd] <= env_eff.val;
                if (env_eff.mw) e_dmem[env_eff.addr[7:2]] <= env_eff.data;
            end
            if (memDumpRead) mem_rd_q <= e_dmem[memDumpAddr[7:2]];
        end
    end

    // ---- reference model: executes the program instruction by instruction ----
    logic [31:0] mprog [256];
    logic [31:0] mregs [32];
    logic [31:0] mmem [64];
    int unsigned mcyc, mpc;
    logic        mto;

    task automatic model_run(input logic [7:0] len);
        logic [31:0] ins;
        eff_t e;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < 64; i++) mmem[i] = '0;
        mcyc = 0; mpc = 0; mto = 1'b0;
        if (len != 8'd0) begin
            forever begin
                ins = mprog[mpc];
                mcyc++;
                if (ins == HALT) break;
                e = decode(ins, mregs[ins[25:21]], mregs[ins[20:16]]);
                if (e.wr && e.rd != 5'd0) mregs[e.rd] = e.val;
                if (e.mw) mmem[e.addr[7:2]] = e.data;
                mpc++;
                if (mcyc == MAXC) begin mto = 1'b1; break; end
            end
        end
    endtask

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    logic [31:0] obs_reg [32];
    logic [31:0] obs_mem [64];

    task automatic kick(input logic [7:0] len);
        @(negedge clk);
        env_clr = 1'b1;
        @(negedge clk);
        env_clr = 1'b0;
        start   = 1'b1;
        progLen = len;
    endtask

    task automatic load_prog(input logic [7:0] len, input logic [11:0][31:0] words);
        for (int i = 0; i < 256; i++) begin
            prog_buf[i] = (i < 12) ? words[i] : '0;
            mprog[i]    = (i < 12 && i < int'(len)) ? words[i] : '0;
        end
    endtask

    task automatic do_run(input logic [7:0] len, input logic [11:0][31:0] words, input bit poke);
        int unsigned nrun, nbeat, beat_err, nwr, wr_err, poke_st, k;
        bit fin, stray, pc_checked;
        logic [31:0] prev_addr, exp_d;
        logic        exp_k;
        logic [15:0] exp_i;
        nrun = 0; nbeat = 0; beat_err = 0; nwr = 0; wr_err = 0; poke_st = 0;
        fin = 1'b0; stray = 1'b0; pc_checked = 1'b0; prev_addr = '1;
        load_prog(len, words);
        model_run(len);
        kick(len);
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            if (it == 0) start = 1'b0;
            if (poke_st == 1) begin start = 1'b0; poke_st = 2; end
            if (instrWrite) begin
                if (nwr >= 12 || instrAddrLoad != 32'(4 * nwr) || instrIn != words[nwr]) wr_err++;
                nwr++;
            end
            if (instrRead) begin
                if (poke && poke_st == 0 && nrun == 1) begin
                    start = 1'b1; progLen = 8'd5; poke_st = 1;
                end
                nrun++;
            end
            if (regDumpSel && !pc_checked) begin
                chk("final_pc", env_pc, 32'(4 * mpc));
                pc_checked = 1'b1;
            end
            if (dumpValid && !(regDumpSel || memDumpSel)) stray = 1'b1;
            if (dumpValid) begin
                k = nbeat;
                if (k < NREG) begin
                    exp_k = 1'b0; exp_i = 16'(k); exp_d = mregs[k];
                    obs_reg[k] = dumpData;
                end else if (k < NREG + NMEM) begin
                    exp_k = 1'b1; exp_i = 16'(k - NREG); exp_d = mmem[k - NREG];
                    obs_mem[k - NREG] = dumpData;
                    if (prev_addr != {14'd0, exp_i, 2'b00}) beat_err++;
                end else begin
                    exp_k = 1'bx; exp_i = 'x; exp_d = 'x;
                    beat_err++;
                end
                if (k < NREG + NMEM && (dumpKind !== exp_k || dumpIndex !== exp_i || dumpData !== exp_d))
                    beat_err++;
                nbeat++;
            end
            if (memDumpSel) prev_addr = memDumpAddr;
            if (done) begin fin = 1'b1; break; end
        end
        chk("done_reached", 32'(fin), 32'd1);
        chk("run_cycles", nrun, mcyc);
        chk("cycleNo", 32'(cycleNo), mcyc);
        chk("timeout", 32'(timeout), 32'(mto));
        chk("beat_count", nbeat, NREG + NMEM);
        chk("dump_stream_errors", beat_err, 0);
        chk("load_writes", nwr, 32'(len));
        chk("load_errors", wr_err, 0);
        chk("stray_dumpValid", 32'(stray), 0);
        chk("done_outputs", {28'd0, pcReset, busy, pcWrite, instrRead}, 32'b1000);
    endtask

    typedef struct packed {
        logic [7:0]        len;
        logic [11:0][31:0] prog;
        logic [15:0]       exp_cyc;
        logic              exp_to;
        logic              is_mem;
        logic [7:0]        idx;
        logic [31:0]       val;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] len, input logic [31:0] w0, w1, w2, w3,
                                input logic [15:0] cyc, input logic to, input logic is_mem,
                                input logic [7:0] idx, input logic [31:0] val);
        vec_t v;
        v = '0;
        v.len = len; v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
        v.exp_cyc = cyc; v.exp_to = to; v.is_mem = is_mem; v.idx = idx; v.val = val;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(1, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return HALT;
            1:       return 32'h0000_0000;
            2, 3:    return {6'h08, rs, rt, imm};
            4:       return {6'h0F, 5'd0, rt, imm};
            5:       return {6'h0D, rs, rt, imm};
            default: return {6'h2B, 5'd0, rt, 16'(4 * $urandom_range(0, 63))};
        endcase
    endfunction

    vec_t vecs [7];
    logic [11:0][31:0] w;
    logic [31:0] obs;
    bit found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(8'd3,  32'h20100002, 32'h22100003, HALT, 32'h0, 16'd3,  1'b0, 1'b0, 8'd16, 32'd5);
        vecs[1] = mk(8'd2,  32'h20100002, 32'h22100003, HALT, 32'h0, 16'd10, 1'b1, 1'b0, 8'd16, 32'd5);
        vecs[2] = mk(8'd4,  32'h3C08DEAD, 32'h3508BEEF, 32'hAC080008, HALT, 16'd4, 1'b0, 1'b1, 8'd2, 32'hDEADBEEF);
        vecs[3] = mk(8'd2,  32'h0, 32'h0, 32'h0, 32'h0, 16'd10, 1'b1, 1'b1, 8'd0, 32'd0);
        vecs[4] = mk(8'd0,  32'h20100002, 32'h0, 32'h0, 32'h0, 16'd0, 1'b0, 1'b0, 8'd16, 32'd0);
        vecs[5] = mk(8'd10, 32'h20080007, 32'h0, 32'h0, 32'h0, 16'd10, 1'b0, 1'b0, 8'd8, 32'd7);
        vecs[5].prog[9] = HALT;
        vecs[6] = mk(8'd1,  HALT, 32'h20080007, 32'h0, 32'h0, 16'd1, 1'b0, 1'b0, 8'd8, 32'd0);

        #12;
        chk("reset_flags", {21'd0, pcReset, busy, done, timeout, dumpValid, instrWrite, instrRead,
                            pcWrite, initializing, regDumpSel, memDumpSel}, 32'b100_0000_0000);
        chk("reset_cycleNo", 32'(cycleNo), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_run(vecs[i].len, vecs[i].prog, (i == 2));
            chk($sformatf("vec%0d_cycleNo", i), 32'(cycleNo), 32'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
            obs = vecs[i].is_mem ? obs_mem[vecs[i].idx[5:0]] : obs_reg[vecs[i].idx[4:0]];
            chk($sformatf("vec%0d_dump_value", i), obs, vecs[i].val);
        end

        // Asynchronous reset in the middle of the register dump.
        load_prog(vecs[0].len, vecs[0].prog);
        kick(vecs[0].len);
        found = 1'b0;
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            start = 1'b0;
            if (regDumpSel && regDumpAddr == 5'd5) begin found = 1'b1; break; end
        end
        chk("reset_mid_dump_reached", 32'(found), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("reset_mid_dump_flags", {27'd0, dumpValid, pcReset, busy, regDumpSel, done}, 32'b01000);
        chk("reset_mid_dump_cycleNo", 32'(cycleNo), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        do_run(vecs[0].len, vecs[0].prog, 1'b0);
        chk("rerun_reg16", obs_reg[16], 32'd5);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 12; i++) w[i] = rand_instr();
            do_run(8'($urandom_range(0, 12)), w, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
